// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and default widths for the VRAM arbiter
package vram_arb_pkg;
  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;
  typedef enum logic [0:0] {READY, CPU_RESP} arb_state_t;
  typedef enum logic [1:0] {GNT_NONE, GNT_VGA, GNT_CPU} grant_t;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating CPU starvation counter
//   clk, rst : clock, async active-high reset
//   inc      : count one denied cycle (saturates at STARVE_MAX)
//   clr      : clear (wins over inc)
//   at_max   : counter has reached STARVE_MAX
module arb_starve_cnt #(
  parameter int STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam logic [7:0] MAX = 8'(STARVE_MAX);
  logic [7:0] cnt;
  assign at_max = cnt == MAX;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= clr ? '0 : (inc && !at_max) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares single-port VRAM between VGA fetch (priority) and CPU with starvation guarantee
//   vga_req/vga_addr -> vga_gnt (comb), vga_rdata/vga_rvalid (1 cycle later)
//   cpu_req/we/addr/wdata -> cpu_ack pulse with cpu_rdata
//   mem_en/we/addr/wdata -> VRAM, mem_rdata <- VRAM (1-cycle read latency)
//   Optional VRAM_ARB_STATS_EN: stat_cpu_stalls, stat_forced saturating 16-bit counters
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_W     = VRAM_ADDR_W,
  parameter int DATA_W     = VRAM_DATA_W,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic [DATA_W-1:0] vga_rdata,
  output logic              vga_rvalid,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_cpu_stalls,
  output logic [15:0]       stat_forced
`endif
);
  arb_state_t state;
  grant_t     gnt;
  logic       we_q, at_max, cpu_gnt, stall, clr;
  // Grants are masked during reset so every output reads 0 while rst is high.
  // The CPU is never granted in CPU_RESP: it still holds req from the access just served.
  always_comb
    gnt = rst ? GNT_NONE :
          (vga_req && (state == CPU_RESP || !cpu_req || !at_max)) ? GNT_VGA :
          (state == READY && cpu_req) ? GNT_CPU : GNT_NONE;
  assign vga_gnt   = gnt == GNT_VGA;
  assign cpu_gnt   = gnt == GNT_CPU;
  assign mem_en    = gnt != GNT_NONE;
  assign mem_we    = cpu_gnt && cpu_we;
  assign mem_addr  = vga_gnt ? vga_addr : cpu_gnt ? cpu_addr : '0;
  assign mem_wdata = cpu_gnt ? cpu_wdata : '0;
  assign cpu_ack   = state == CPU_RESP;
  assign cpu_rdata = (cpu_ack && !we_q) ? mem_rdata : '0;
  assign vga_rdata = vga_rvalid ? mem_rdata : '0;
  assign stall     = state == READY && cpu_req && !cpu_gnt;
  assign clr       = state == READY && (!cpu_req || cpu_gnt);
  arb_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall),
    .clr   (clr),
    .at_max(at_max)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state      <= READY;
      we_q       <= 1'b0;
      vga_rvalid <= 1'b0;
    end else begin
      state      <= cpu_gnt ? CPU_RESP : READY;
      we_q       <= cpu_gnt ? cpu_we : we_q;
      vga_rvalid <= vga_gnt;
    end
`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stat_cpu_stalls <= '0;
      stat_forced     <= '0;
    end else begin
      stat_cpu_stalls <= (stall && stat_cpu_stalls != 16'hFFFF) ? stat_cpu_stalls + 1'b1 : stat_cpu_stalls;
      stat_forced     <= (cpu_gnt && vga_req && stat_forced != 16'hFFFF) ? stat_forced + 1'b1 : stat_forced;
    end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table-driven and sequence checks of vram_arbiter with a VRAM model and VGA scoreboard
module tb_vram_arbiter;
  logic        clk = 1'b0, rst = 1'b1;
  logic        vga_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] vga_addr = '0, cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic        vga_gnt, vga_rvalid, cpu_ack, mem_en, mem_we;
  logic [7:0]  vga_rdata, cpu_rdata, mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic [15:0] mem_addr;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0] stat_cpu_stalls, stat_forced;
`endif
  int tests = 0, fails = 0;
  logic [7:0] sb[$];
  logic [7:0] vram [0:65535];

  vram_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt),
    .vga_rdata(vga_rdata), .vga_rvalid(vga_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .stat_cpu_stalls(stat_cpu_stalls), .stat_forced(stat_forced)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else mem_rdata <= vram[mem_addr];
    end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (vga_rvalid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL vga_rvalid: got unexpected valid data %0h expected none", vga_rdata);
      end else chk("vga_rdata", {56'b0, vga_rdata}, {56'b0, sb.pop_front()});
    end

  function automatic logic [63:0] all_outs();
    return {19'b0, vga_gnt, vga_rvalid, vga_rdata, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic vreq; logic [15:0] vaddr;
    logic creq, cwe; logic [15:0] caddr; logic [7:0] cwd;
    logic gnt, en, we; logic [15:0] maddr; logic [7:0] mwd;
    logic ack; logic [7:0] crd; logic [7:0] vdata;
  } vec_t;

  vec_t tbl [13];
  logic prev_gnt;

  initial begin
    vram[16'h0020] = 8'h3C;
    vram[16'h1234] = 8'h77;
    tbl[0]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0, 8'h00, 8'h00};
    tbl[1]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h00, 8'h00};
    tbl[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h3C, 8'h00};
    tbl[4]  = '{1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h00, 8'h77};
    tbl[5]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[6]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h0040, 8'h11, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b0, 8'h00, 8'h77};
    tbl[7]  = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0040, 8'h11, 1'b0, 1'b1, 1'b1, 16'h0040, 8'h11, 1'b0, 8'h00, 8'h00};
    tbl[8]  = '{1'b1, 16'h1234, 1'b1, 1'b1, 16'h0040, 8'h11, 1'b1, 1'b1, 1'b0, 16'h1234, 8'h00, 1'b1, 8'h00, 8'h77};
    tbl[9]  = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[10] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 8'h00, 8'h00};
    tbl[11] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0040, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 8'h11, 8'h00};
    tbl[12] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 8'h00, 8'h00};

    tick();
    tick();
    chk("reset_outs", all_outs(), 64'b0);
    @(negedge clk) rst = 1'b0;
    tick();

    prev_gnt = 1'b0;
    for (int i = 0; i < 13; i++) begin
      vga_req = tbl[i].vreq; vga_addr = tbl[i].vaddr;
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].caddr; cpu_wdata = tbl[i].cwd;
      @(negedge clk);
      chk($sformatf("v%0d_gnt", i), {63'b0, vga_gnt}, {63'b0, tbl[i].gnt});
      chk($sformatf("v%0d_mem", i), {38'b0, mem_en, mem_we, mem_addr, mem_wdata},
          {38'b0, tbl[i].en, tbl[i].we, tbl[i].maddr, tbl[i].mwd});
      chk($sformatf("v%0d_cpu", i), {55'b0, cpu_ack, cpu_rdata}, {55'b0, tbl[i].ack, tbl[i].crd});
      chk($sformatf("v%0d_rvalid", i), {63'b0, vga_rvalid}, {63'b0, prev_gnt});
      if (tbl[i].gnt) sb.push_back(tbl[i].vdata);
      prev_gnt = tbl[i].gnt;
      tick();
    end
    vga_req = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    tick();
    tick();

    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    @(negedge clk);
    chk("rst_acc_en", {63'b0, mem_en}, 64'd1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_outs", all_outs(), 64'b0);
    tick();
    chk("rst_hold_outs", all_outs(), 64'b0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rerq_acc", {46'b0, mem_en, mem_we, mem_addr}, {46'b0, 1'b1, 1'b0, 16'h0020});
    tick();
    chk("rerq_ack", {55'b0, cpu_ack, cpu_rdata}, {55'b0, 1'b1, 8'h3C});
    cpu_req = 1'b0; cpu_addr = '0;
    tick();
    chk("rerq_ack_once", {63'b0, cpu_ack}, 64'd0);

    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    tick();
    vga_req = 1'b1; vga_addr = 16'h1234;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("st%0d_gnt", c), {63'b0, vga_gnt}, {63'b0, c != 8});
      chk($sformatf("st%0d_en", c), {63'b0, mem_en}, 64'd1);
      chk($sformatf("st%0d_ack", c), {63'b0, cpu_ack}, {63'b0, c == 9});
      if (c == 8) chk("st_cpu_addr", {48'b0, mem_addr}, 64'h0020);
      if (c == 9) chk("st_rdata", {56'b0, cpu_rdata}, 64'h3C);
      if (c != 8) sb.push_back(8'h77);
      tick();
      if (c == 9) begin cpu_req = 1'b0; cpu_addr = '0; end
    end
    vga_req = 1'b0; vga_addr = '0;
    tick();
    tick();
`ifdef VRAM_ARB_STATS_EN
    chk("stat_cpu_stalls", {48'b0, stat_cpu_stalls}, 64'd8);
    chk("stat_forced", {48'b0, stat_forced}, 64'd1);
`endif
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
